// File: rtl/descriptor_nn_matcher.sv
// Nearest-neighbour descriptor matcher.
// Streams N candidate descriptors from a synchronous-read RAM into an external
// L1 distance unit, tracks the best and second-best distances as results come
// back two cycles after each read, then applies the Lowe ratio test.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start; N==0 requests finish here immediately
// ISSUE  | one RAM read per cycle, addresses 0..N-1
// DRAIN  | reads stopped, last distances still in flight
// DECIDE | result registers valid, done pulse, back to IDLE
module descriptor_nn_matcher #(
   parameter int IDX_W     = 10,
   parameter int RATIO_NUM = 4,
   parameter int RATIO_DEN = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [383:0]       query_desc,
   input  logic [IDX_W:0]     num_cand,
   output logic               busy,
   output logic               cand_rd,
   output logic [IDX_W-1:0]   cand_addr,
   input  logic [383:0]       cand_data,
   output logic [383:0]       dist_a,
   output logic [383:0]       dist_b,
   input  logic [14:0]        dist_in,
   output logic               done,
   output logic               match_valid,
   output logic [IDX_W-1:0]   best_idx,
   output logic [14:0]        best_dist,
   output logic [14:0]        second_dist
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DECIDE} state_t;

   localparam logic [14:0] DIST_MAX = 15'h7FFF;

   state_t           state, state_nxt;
   logic [IDX_W:0]   n_reg;
   logic [IDX_W:0]   n_last;
   logic             last_addr;
   logic             go_run;
   logic             go_zero;
   logic             fin;

   logic             v1, v2;
   logic [IDX_W-1:0] i1, i2;

   logic [14:0]      w_best, w_second;
   logic [IDX_W-1:0] w_idx;
   logic [14:0]      upd_best, upd_second;
   logic [IDX_W-1:0] upd_idx;
   logic [19:0]      prod_best, prod_second;

   assign n_last    = n_reg - {{IDX_W{1'b0}}, 1'b1};
   assign last_addr = ({1'b0, cand_addr} == n_last);
   assign go_run    = (state == IDLE) && start && (num_cand != '0);
   assign go_zero   = (state == IDLE) && start && (num_cand == '0);
   // Last distance is captured on the same edge that leaves DRAIN.
   assign fin       = (state == DRAIN) && !v1;

   assign dist_b    = cand_data;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (go_run) state_nxt = ISSUE;
         ISSUE:   if (last_addr) state_nxt = DRAIN;
         DRAIN:   if (!v1) state_nxt = DECIDE;
         DECIDE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Moore outputs decoded from state.
   always_comb begin
      busy    = (state != IDLE);
      cand_rd = (state == ISSUE);
   end

   // Query / count latch and read address counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dist_a    <= '0;
         n_reg     <= '0;
         cand_addr <= '0;
      end else begin
         if (go_run) begin
            dist_a    <= query_desc;
            n_reg     <= num_cand;
            cand_addr <= '0;
         end else if (state == ISSUE) begin
            cand_addr <= last_addr ? '0 : cand_addr + IDX_W'(1);
         end
      end
   end

   // Two-stage valid/index shift register matching the RAM + distance unit latency.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         i1 <= '0;
         i2 <= '0;
      end else begin
         v1 <= cand_rd;
         i1 <= cand_addr;
         v2 <= v1;
         i2 <= i1;
      end
   end

   // Best/second-best update for the distance arriving this cycle; strict
   // compare so an equal distance never displaces the earlier index.
   always_comb begin
      upd_best   = w_best;
      upd_second = w_second;
      upd_idx    = w_idx;
      if (v2) begin
         if (dist_in < w_best) begin
            upd_second = w_best;
            upd_best   = dist_in;
            upd_idx    = i2;
         end else if (dist_in < w_second) begin
            upd_second = dist_in;
         end
      end
   end

   // Working best/second registers.
   always_ff @(posedge clk) begin
      if (!rst_n || go_run) begin
         w_best   <= DIST_MAX;
         w_second <= DIST_MAX;
         w_idx    <= '0;
      end else begin
         w_best   <= upd_best;
         w_second <= upd_second;
         w_idx    <= upd_idx;
      end
   end

   // Ratio test operands; 20 bits holds 7FFF times either ratio term.
   always_comb begin
      prod_best   = {5'b0, upd_best} * 20'(RATIO_DEN);
      prod_second = {5'b0, upd_second} * 20'(RATIO_NUM);
   end

   // Published result and done pulse; held between completions.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         done        <= 1'b0;
         match_valid <= 1'b0;
         best_idx    <= '0;
         best_dist   <= DIST_MAX;
         second_dist <= DIST_MAX;
      end else begin
         done <= fin || go_zero;
         if (fin) begin
            match_valid <= (prod_best < prod_second);
            best_idx    <= upd_idx;
            best_dist   <= upd_best;
            second_dist <= upd_second;
         end else if (go_zero) begin
            match_valid <= 1'b0;
            best_idx    <= '0;
            best_dist   <= DIST_MAX;
            second_dist <= DIST_MAX;
         end
      end
   end

endmodule
